io_bus_master: RTL and testbench
================================

IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: number of extra ACCESS cycles per bus transaction (0..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CPU-side request present.
REQ-005 req_ready  output  1  block accepts a request this cycle; high only in IDLE.
REQ-006 req_write  input  1  1 = write, 0 = read; sampled on accept.
REQ-007 req_addr  input  8  target I/O address; sampled on accept.
REQ-008 req_wdata  input  8  write data; sampled on accept.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  CPU consumes response.
REQ-011 rsp_rdata  output  8  read result; 0x00 for write responses.
REQ-012 addr  output  8  bus address to I/O responder.
REQ-013 write_data  output  8  bus write data.
REQ-014 write_en  output  1  bus write strobe.
REQ-015 read_en  output  1  bus read enable.
REQ-016 read_data  input  8  combinational read data from responder, valid while read_en high.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP; one transaction in flight at most.
REQ-019 IDLE: req_ready=1; on req_valid=1 at a clock edge, req_write/req_addr/req_wdata SHALL be registered and state SHALL go to ACCESS.
REQ-020 ACCESS SHALL last exactly 1+WAIT_CYCLES cycles, counted by an internal down-counter loaded on accept.
REQ-021 addr and write_data SHALL equal the captured request for the whole of ACCESS and SHALL hold those values after ACCESS until the next accept.
REQ-022 Read: read_en SHALL be high in every ACCESS cycle; write_en SHALL remain 0.
REQ-023 Write: write_en SHALL be high only in the final ACCESS cycle (one pulse per transaction); read_en SHALL remain 0.
REQ-024 write_en and read_en SHALL be 0 in IDLE and RESP and SHALL never be high simultaneously.
REQ-025 Read: read_data SHALL be sampled into rsp_rdata at the edge ending the final ACCESS cycle; write: rsp_rdata SHALL be loaded with 0x00 at that edge.
REQ-026 RESP: rsp_valid=1; rsp_rdata stable; state SHALL return to IDLE at the first edge with rsp_ready=1.
REQ-027 rsp_ready ignored outside RESP; req_valid ignored outside IDLE.
REQ-028 Latency: accept at edge N -> ACCESS cycles N+1..N+1+WAIT_CYCLES -> rsp_valid from cycle N+2+WAIT_CYCLES; earliest next accept one cycle after the rsp handshake.
REQ-029 rsp_valid and req_ready SHALL never be high simultaneously.

Reset
REQ-030 reset=1 SHALL force IDLE immediately, independent of clk, even mid-ACCESS or mid-RESP; the in-flight transaction is discarded.
REQ-031 Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0x00, addr=0x00, write_data=0x00, write_en=0, read_en=0, busy=0, wait counter=0.
REQ-032 First accept SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-033 Reset check: assert reset asynchronously between edges -> all outputs at REQ-031 values within the same cycle.
REQ-034 WAIT_CYCLES=0, write 0x05 to 0x00 -> addr=0x00, write_data=0x05, write_en high exactly 1 cycle; rsp_valid at N+2, rsp_rdata=0x00.
REQ-035 WAIT_CYCLES=2, read 0x04 with read_data=0x0A -> read_en high 3 cycles, write_en 0, rsp_rdata=0x0A at N+4.
REQ-036 Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata held, req_ready=0, busy=1; returns to IDLE the edge rsp_ready=1.
REQ-037 Reset mid-ACCESS of a read (WAIT_CYCLES=3) -> read_en drops at once, no rsp_valid ever issued, next request completes normally.
REQ-038 Back-to-back: req_valid held high with rsp_ready=1 -> write then read complete with strobes never overlapping and exactly one write_en pulse.

Source files
------------

// File: rtl/io_bus_master.sv
// Single-outstanding CPU-to-I/O bus master: accepts a request, drives the I/O
// bus for 1+WAIT_CYCLES cycles, then holds the response until the CPU takes it.
module io_bus_master #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [7:0] addr,
  output logic [7:0] write_data,
  output logic       write_en,
  output logic       read_en,
  input  logic [7:0] read_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       is_write;
  logic       accept;
  logic       last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: if (wait_cnt == 4'd0) begin
        last      = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus address/data stay at the last request until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      is_write   <= 1'b0;
      addr       <= 8'h00;
      write_data <= 8'h00;
      rsp_rdata  <= 8'h00;
    end else begin
      if (accept) begin
        wait_cnt   <= WAIT_LOAD;
        is_write   <= req_write;
        addr       <= req_addr;
        write_data <= req_wdata;
      end else if (state == ACCESS && !last) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (last) rsp_rdata <= is_write ? 8'h00 : read_data;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign read_en   = (state == ACCESS) && !is_write;
  // Write strobe fires once, in the cycle the counter has run out.
  assign write_en  = (state == ACCESS) && is_write && (wait_cnt == 4'd0);

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: three instances with WAIT_CYCLES 0, 2 and 3
// share clk/reset; a small combinational responder supplies read data.
module tb_io_bus_master;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid [N];
  logic       req_write [N];
  logic       rsp_ready [N];
  logic [7:0] req_addr  [N];
  logic [7:0] req_wdata [N];
  logic [7:0] read_data [N];
  logic       req_ready [N];
  logic       rsp_valid [N];
  logic       write_en  [N];
  logic       read_en   [N];
  logic       busy      [N];
  logic [7:0] rsp_rdata [N];
  logic [7:0] addr      [N];
  logic [7:0] write_data[N];

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt [N];
  int re_cnt [N];
  int rv_cnt [N];
  int ovl_cnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    io_bus_master #(.WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .addr      (addr[g]),
      .write_data(write_data[g]),
      .write_en  (write_en[g]),
      .read_en   (read_en[g]),
      .read_data (read_data[g]),
      .busy      (busy[g])
    );
    assign read_data[g] = (addr[g] == 8'h04) ? 8'h0A : (addr[g] ^ 8'hA5);
  end

  // Per-cycle strobe/response counters and illegal-overlap detector.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (write_en[k])  we_cnt[k] <= we_cnt[k] + 1;
      if (read_en[k])   re_cnt[k] <= re_cnt[k] + 1;
      if (rsp_valid[k]) rv_cnt[k] <= rv_cnt[k] + 1;
      if ((write_en[k] && read_en[k]) || (rsp_valid[k] && req_ready[k]))
        ovl_cnt <= ovl_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input int k);
    chk("rst_req_ready", req_ready[k], 1);
    chk("rst_rsp_valid", rsp_valid[k], 0);
    chk("rst_rsp_rdata", rsp_rdata[k], 8'h00);
    chk("rst_addr", addr[k], 8'h00);
    chk("rst_write_data", write_data[k], 8'h00);
    chk("rst_write_en", write_en[k], 0);
    chk("rst_read_en", read_en[k], 0);
    chk("rst_busy", busy[k], 0);
  endtask

  initial begin
    int w0, r0, v0;
    reset   = 1'b1;
    ovl_cnt = 0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      rsp_ready[k] = 1'b0;
      req_addr[k]  = 8'h00;
      req_wdata[k] = 8'h00;
      we_cnt[k] = 0;
      re_cnt[k] = 0;
      rv_cnt[k] = 0;
    end

    #23;
    for (int k = 0; k < N; k++) chk_rst(k);
    #4 reset = 1'b0;
    tick();

    // W=0 write 0x05 -> 0x00
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h00; req_wdata[0] = 8'h05;
    w0 = we_cnt[0];
    tick();
    req_valid[0] = 1'b0;
    chk("w0_acc_write_en", write_en[0], 1);
    chk("w0_acc_read_en", read_en[0], 0);
    chk("w0_acc_addr", addr[0], 8'h00);
    chk("w0_acc_wdata", write_data[0], 8'h05);
    chk("w0_acc_busy", busy[0], 1);
    chk("w0_acc_rsp_valid", rsp_valid[0], 0);
    tick();
    chk("w0_rsp_valid", rsp_valid[0], 1);
    chk("w0_rsp_rdata", rsp_rdata[0], 8'h00);
    chk("w0_rsp_write_en", write_en[0], 0);
    chk("w0_rsp_req_ready", req_ready[0], 0);
    tick();
    chk("w0_idle_req_ready", req_ready[0], 1);
    chk("w0_idle_rsp_valid", rsp_valid[0], 0);
    chk("w0_hold_wdata", write_data[0], 8'h05);
    chk("w0_we_pulses", we_cnt[0] - w0, 1);

    // W=2 read 0x04 -> 0x0A
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h04;
    r0 = re_cnt[1];
    tick();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("r2_acc_read_en", read_en[1], 1);
      chk("r2_acc_write_en", write_en[1], 0);
      chk("r2_acc_rsp_valid", rsp_valid[1], 0);
      chk("r2_acc_addr", addr[1], 8'h04);
      tick();
    end
    chk("r2_rsp_valid", rsp_valid[1], 1);
    chk("r2_rsp_rdata", rsp_rdata[1], 8'h0A);
    chk("r2_rsp_read_en", read_en[1], 0);
    tick();
    chk("r2_idle_req_ready", req_ready[1], 1);
    chk("r2_re_cycles", re_cnt[1] - r0, 3);

    // W=2 back-pressure: read 0x20 -> 0x85, rsp_ready low for 5 cycles
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h20;
    tick();
    req_valid[1] = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid[1], 1);
      chk("bp_rsp_rdata", rsp_rdata[1], 8'h85);
      chk("bp_req_ready", req_ready[1], 0);
      chk("bp_busy", busy[1], 1);
      tick();
    end
    rsp_ready[1] = 1'b1;
    chk("bp_still_valid", rsp_valid[1], 1);
    tick();
    chk("bp_idle_req_ready", req_ready[1], 1);
    chk("bp_idle_rsp_valid", rsp_valid[1], 0);
    chk("bp_idle_busy", busy[1], 0);
    chk("bp_hold_addr", addr[1], 8'h20);

    // W=3 read 0x30 aborted by async reset mid-ACCESS
    rsp_ready[2] = 1'b1;
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 8'h30;
    v0 = rv_cnt[2];
    tick();
    req_valid[2] = 1'b0;
    chk("ab_acc1_read_en", read_en[2], 1);
    tick();
    chk("ab_acc2_read_en", read_en[2], 1);
    #2 reset = 1'b1;
    #1;
    chk_rst(2);
    tick();
    tick();
    #2 reset = 1'b0;
    repeat (3) tick();
    chk("ab_no_rsp", rv_cnt[2] - v0, 0);
    w0 = we_cnt[2];
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 8'h31; req_wdata[2] = 8'h3C;
    tick();
    req_valid[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ab_w_write_en", write_en[2], (i == 3) ? 1 : 0);
      tick();
    end
    chk("ab_w_rsp_valid", rsp_valid[2], 1);
    chk("ab_w_rsp_rdata", rsp_rdata[2], 8'h00);
    chk("ab_w_addr", addr[2], 8'h31);
    chk("ab_w_wdata", write_data[2], 8'h3C);
    tick();
    chk("ab_w_we_pulses", we_cnt[2] - w0, 1);
    chk("ab_rsp_count", rv_cnt[2] - v0, 1);

    // W=0 back-to-back: write 0x99->0x40 then read 0x41 (-> 0xE4)
    rsp_ready[0] = 1'b1;
    w0 = we_cnt[0];
    r0 = re_cnt[0];
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h40; req_wdata[0] = 8'h99;
    tick();
    req_write[0] = 1'b0; req_addr[0] = 8'h41;
    chk("bb_w_write_en", write_en[0], 1);
    chk("bb_w_read_en", read_en[0], 0);
    tick();
    chk("bb_w_rsp_valid", rsp_valid[0], 1);
    chk("bb_w_rsp_rdata", rsp_rdata[0], 8'h00);
    chk("bb_w_req_ready", req_ready[0], 0);
    tick();
    chk("bb_idle_req_ready", req_ready[0], 1);
    chk("bb_idle_addr", addr[0], 8'h40);
    tick();
    req_valid[0] = 1'b0;
    chk("bb_r_read_en", read_en[0], 1);
    chk("bb_r_write_en", write_en[0], 0);
    chk("bb_r_addr", addr[0], 8'h41);
    tick();
    chk("bb_r_rsp_valid", rsp_valid[0], 1);
    chk("bb_r_rsp_rdata", rsp_rdata[0], 8'hE4);
    tick();
    chk("bb_we_pulses", we_cnt[0] - w0, 1);
    chk("bb_re_cycles", re_cnt[0] - r0, 1);
    chk("bb_idle_busy", busy[0], 0);

    tick();
    chk("no_overlap", ovl_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
